// File: rtl/mac_sequencer.sv
// Tap-counter sequencer for the MAC pipeline: clears the external 4-bit counter,
// accumulates a_in*b_in over LEN taps and publishes the dot product with a done pulse.
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN    = 8
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        count_out,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              count_enb,
  output logic              count_reset,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'(LEN - 1);
  localparam int         PAD_W    = ACC_W + 1 - 2 * DATA_W;

  state_t                  state_q;
  logic [ACC_W-1:0]        acc_q;
  logic                    ovf_q;
  logic [2*DATA_W-1:0]     prod_d;
  logic [ACC_W:0]          sumWide_d;
  logic                    ovf_d;

  // One extra bit on the add exposes the carry-out that feeds the sticky overflow.
  always_comb begin
    prod_d    = a_in * b_in;
    sumWide_d = {1'b0, acc_q} + {{PAD_W{1'b0}}, prod_d};
    ovf_d     = ovf_q | sumWide_d[ACC_W];
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_enb   <= 1'b0;
      count_reset <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CLEAR;
            count_reset <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CLEAR: begin
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          count_reset <= 1'b0;
          if (abort) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_q   <= ACCUM;
            count_enb <= 1'b1;
          end
        end
        ACCUM: begin
          // Abort wins over the last-tap check and skips this cycle's product.
          if (abort) begin
            state_q   <= IDLE;
            count_enb <= 1'b0;
            busy      <= 1'b0;
          end else begin
            acc_q <= sumWide_d[ACC_W-1:0];
            ovf_q <= ovf_d;
            if (count_out == LAST_TAP) begin
              state_q     <= DONE;
              count_enb   <= 1'b0;
              count_reset <= 1'b1;
              done        <= 1'b1;
              result      <= sumWide_d[ACC_W-1:0];
              overflow    <= ovf_d;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          count_reset <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          count_enb   <= 1'b0;
          count_reset <= 1'b0;
          done        <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized scoreboard bench for mac_sequencer, with a behavioural model of the
// external tap counter and operand memories indexed by count_out.
module tb_mac_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN    = 4;

  logic              clk_out = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [3:0]        count_out;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              count_enb;
  logic              count_reset;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             ovf;
    int               doneCyc;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] opA[16];
  logic [DATA_W-1:0] opB[16];
  logic [ACC_W-1:0]  lastRes;
  logic              lastOvf;
  int                tests   = 0;
  int                fails   = 0;
  int                cyc     = 0;
  int                crCount = 0;

  mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
    .clk_out    (clk_out),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .count_out  (count_out),
    .a_in       (a_in),
    .b_in       (b_in),
    .count_enb  (count_enb),
    .count_reset(count_reset),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overflow   (overflow)
  );

  always #5 clk_out = ~clk_out;

  always @(posedge clk_out) cyc <= cyc + 1;

  // Tap counter downstream of the sequencer, sharing its reset.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst)              count_out <= 4'd0;
    else if (count_reset) count_out <= 4'd0;
    else if (count_enb)   count_out <= count_out + 4'd1;
  end

  always_comb begin
    a_in = opA[count_out];
    b_in = opB[count_out];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Dot product from the plain sum; any carry over the run means the total reached 2^ACC_W.
  function automatic exp_t model(input int e0);
    exp_t   r;
    longint total = 0;
    for (int i = 0; i < LEN; i++) total += longint'(opA[i]) * longint'(opB[i]);
    r.res     = total[ACC_W-1:0];
    r.ovf     = (total >= (longint'(1) << ACC_W));
    r.doneCyc = e0 + LEN + 1;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_out) begin
    exp_t e;
    if (rst === 1'b0 && count_reset === 1'b1) crCount <= crCount + 1;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
        checkOutput("done cycle", cyc, e.doneCyc);
      end
    end
  end

  task automatic startRun(output int e0);
    @(negedge clk_out);
    start = 1'b1;
    @(negedge clk_out);
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 200) begin
      @(negedge clk_out);
      n++;
    end
    if (n >= 200) checkOutput("idle timeout", 0, 1);
    checkOutput("held result", 32'(result), 32'(lastRes));
    checkOutput("held overflow", 32'(overflow), 32'(lastOvf));
  endtask

  task automatic randomOps();
    for (int i = 0; i < 16; i++) begin
      opA[i] = DATA_W'($urandom);
      opB[i] = DATA_W'($urandom);
    end
  endtask

  task automatic applyStimulus();
    int   e0;
    exp_t e;
    startRun(e0);
    e = model(e0);
    sb.push_back(e);
    lastRes = e.res;
    lastOvf = e.ovf;
    waitIdle();
  endtask

  // Aborts at offset k after the CLEAR cycle: 0 aborts in CLEAR, 1..LEN in ACCUM.
  task automatic abortRun(input int k);
    int e0;
    startRun(e0);
    for (int i = 0; i < k; i++) @(negedge clk_out);
    abort = 1'b1;
    @(negedge clk_out);
    abort = 1'b0;
    checkOutput("busy after abort", 32'(busy), 0);
    checkOutput("enb after abort", 32'(count_enb), 0);
    waitIdle();
  endtask

  initial begin
    int crBase;
    int e0;
    int n;
    rst   = 1'b1;
    start = 1'($urandom);
    abort = 1'($urandom);
    randomOps();
    lastRes = '0;
    lastOvf = 1'b0;
    repeat (3) @(negedge clk_out);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset count_enb", 32'(count_enb), 0);
    checkOutput("reset count_reset", 32'(count_reset), 0);
    checkOutput("reset result", 32'(result), 0);
    checkOutput("reset overflow", 32'(overflow), 0);
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    @(negedge clk_out);

    // Basic run: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 16; i++) begin
      opA[i] = DATA_W'(i + 1);
      opB[i] = DATA_W'(i + 5);
    end
    crBase = crCount;
    applyStimulus();
    checkOutput("basic result", 32'(result), 70);
    checkOutput("count_reset pulses", crCount - crBase, 2);

    // 4*255*255 = 260100 wraps to 63492 in 16 bits
    for (int i = 0; i < 16; i++) begin
      opA[i] = 8'd255;
      opB[i] = 8'd255;
    end
    applyStimulus();
    checkOutput("ovf result", 32'(result), 63492);
    checkOutput("ovf flag", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      opA[i] = 8'd1;
      opB[i] = 8'd1;
    end
    applyStimulus();
    checkOutput("ovf cleared", 32'(overflow), 0);
    checkOutput("ones result", 32'(result), 4);

    // Abort in the third ACCUM cycle after a result of 70
    for (int i = 0; i < 16; i++) begin
      opA[i] = DATA_W'(i + 1);
      opB[i] = DATA_W'(i + 5);
    end
    applyStimulus();
    randomOps();
    abortRun(3);
    checkOutput("result after abort", 32'(result), 70);
    randomOps();
    applyStimulus();

    // start held high: runs every LEN+3 cycles
    for (int i = 0; i < 16; i++) begin
      opA[i] = 8'd1;
      opB[i] = 8'd1;
    end
    @(negedge clk_out);
    start = 1'b1;
    @(negedge clk_out);
    e0 = cyc;
    for (int k = 0; k < 3; k++) sb.push_back(model(e0 + k * (LEN + 3)));
    n = 0;
    while (cyc < e0 + 2 * (LEN + 3) + LEN + 1 && n < 100) begin
      @(negedge clk_out);
      n++;
    end
    start = 1'b0;
    lastRes = 16'd4;
    lastOvf = 1'b0;
    waitIdle();

    // Reset in the middle of ACCUM
    randomOps();
    startRun(e0);
    repeat (2) @(negedge clk_out);
    rst = 1'b1;
    #1;
    checkOutput("midrun rst busy", 32'(busy), 0);
    checkOutput("midrun rst enb", 32'(count_enb), 0);
    checkOutput("midrun rst result", 32'(result), 0);
    @(negedge clk_out);
    rst     = 1'b0;
    lastRes = '0;
    lastOvf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    opA[0] = 8'd3;
    opB[0] = 8'd9;
    applyStimulus();
    checkOutput("post-rst result", 32'(result), 27);

    // Random runs with occasional aborts, including in CLEAR and on the last tap
    for (int r = 0; r < 25; r++) begin
      randomOps();
      if ($urandom_range(0, 3) == 0) abortRun(int'($urandom_range(0, LEN)));
      else applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
